ss_wb_arb: RTL and testbench

//  4-channel round-robin arbiter and multiplexer for the shared Wishbone master port (wbs_*4).

---
 rtl/ssdma_pkg.sv | 11 +
 rtl/ss_wb_arb_if.sv | 30 +++
 rtl/ss_rr_pick.sv | 16 +
 rtl/ss_wb_arb.sv | 103 ++++++++++
 tb/tb_ss_wb_arb.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ssdma_pkg.sv
// ssdma_pkg: shared channel count, arbiter state encoding, lane slice widths and helpers
package ssdma_pkg;
  localparam int NCH = 4;
  localparam int PW = $clog2(NCH);
  localparam int SELW = 4;
  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_e;
  function automatic logic [PW-1:0] oh2idx(input logic [NCH-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < NCH; i++) if (oh[i]) oh2idx = PW'(i);
  endfunction
endpackage

// File: rtl/ss_wb_arb_if.sv
// ss_wb_arb_if: channel-side and shared-master-side Wishbone signals of the arbiter
interface ss_wb_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  import ssdma_pkg::*;
  logic [NCH-1:0] m_cyc_i, m_stb_i, m_we_i, m_cab_i;
  logic [SELW*NCH-1:0] m_sel_i;
  logic [AW*NCH-1:0] m_adr_i;
  logic [DW*NCH-1:0] m_dat_i, m_dat64_i;
  logic [DW-1:0] m_dat_o, m_dat64_o;
  logic [NCH-1:0] m_ack_o, m_err_o, m_rty_o, gnt;
  logic wbs_cyc4, wbs_stb4, wbs_we4, wbs_cab4;
  logic [SELW-1:0] wbs_sel4;
  logic [AW-1:0] wbs_adr4;
  logic [DW-1:0] wbs_dat_i4, wbs_dat64_i4, wbs_dat_o4, wbs_dat64_o4;
  logic wbs_ack4, wbs_err4, wbs_rty4;
  modport slave (
    input m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_sel_i, m_adr_i, m_dat_i, m_dat64_i,
    input wbs_dat_o4, wbs_dat64_o4, wbs_ack4, wbs_err4, wbs_rty4,
    output m_dat_o, m_dat64_o, m_ack_o, m_err_o, m_rty_o, gnt,
    output wbs_cyc4, wbs_stb4, wbs_we4, wbs_cab4, wbs_sel4, wbs_adr4, wbs_dat_i4, wbs_dat64_i4
  );
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_cab_i, m_sel_i, m_adr_i, m_dat_i, m_dat64_i,
    output wbs_dat_o4, wbs_dat64_o4, wbs_ack4, wbs_err4, wbs_rty4,
    input m_dat_o, m_dat64_o, m_ack_o, m_err_o, m_rty_o, gnt,
    input wbs_cyc4, wbs_stb4, wbs_we4, wbs_cab4, wbs_sel4, wbs_adr4, wbs_dat_i4, wbs_dat64_i4
  );
endinterface

// File: rtl/ss_rr_pick.sv
// ss_rr_pick: first requesting channel at or above ptr, wrapping modulo NCH, as one-hot
module ss_rr_pick
  import ssdma_pkg::*;
(
  input  logic [NCH-1:0] req,
  input  logic [PW-1:0]  ptr,
  output logic [NCH-1:0] win,
  output logic           valid
);
  // scan downward from the farthest slot so the closest request to ptr is written last
  always_comb begin
    win = '0;
    for (int k = NCH - 1; k >= 0; k--) if (req[ptr + PW'(k)]) win = NCH'(1) << (ptr + PW'(k));
  end
  assign valid = |req;
endmodule

// File: rtl/ss_wb_arb.sv
// ss_wb_arb: 4-channel round-robin Wishbone arbiter and mux; SS_ARB_TIMEOUT_EN adds a stall watchdog
module ss_wb_arb
  import ssdma_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef SS_ARB_TIMEOUT_EN
  , parameter int TIMEOUT = 255
`endif
) (
  input logic        wb_clk_i,
  input logic        wb_rst_i,
  ss_wb_arb_if.slave bus
);
  state_e state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d, win;
  logic [PW-1:0] ptr_q, ptr_d;
  logic valid, cyc_m, stb_m, we_m, cab_m, resp, to;
  logic [SELW-1:0] sel_m;
  logic [AW-1:0] adr_m;
  logic [DW-1:0] dat_m, d64_m;
  ss_rr_pick u_pick (.req(bus.m_cyc_i), .ptr(ptr_q), .win(win), .valid(valid));
  // grant FSM: pick in IDLE, hold while owner keeps cyc, one dead HOLD cycle before re-arbitrating
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    case (state_q)
      IDLE: if (valid) begin
        state_d = BUSY;
        gnt_d = win;
      end
      BUSY: if (!(|(bus.m_cyc_i & gnt_q))) begin
        state_d = HOLD;
        gnt_d = '0;
        ptr_d = oh2idx(gnt_q) + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  // arbiter state registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      gnt_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end
  // route the granted channel's request to the master port; all zero with no grant
  always_comb begin
    cyc_m = 1'b0;
    stb_m = 1'b0;
    we_m = 1'b0;
    cab_m = 1'b0;
    sel_m = '0;
    adr_m = '0;
    dat_m = '0;
    d64_m = '0;
    for (int n = 0; n < NCH; n++) if (gnt_q[n]) begin
      cyc_m = bus.m_cyc_i[n];
      stb_m = bus.m_stb_i[n];
      we_m = bus.m_we_i[n];
      cab_m = bus.m_cab_i[n];
      sel_m = bus.m_sel_i[SELW*n +: SELW];
      adr_m = bus.m_adr_i[AW*n +: AW];
      dat_m = bus.m_dat_i[DW*n +: DW];
      d64_m = bus.m_dat64_i[DW*n +: DW];
    end
  end
  assign resp = bus.wbs_ack4 | bus.wbs_err4 | bus.wbs_rty4;
`ifdef SS_ARB_TIMEOUT_EN
  localparam int CW = 16;
  logic [CW-1:0] cnt_q, cnt_d;
  assign to = stb_m && !resp && cnt_q == CW'(TIMEOUT - 1);
  // count stalled strobe cycles; restart on any response, on timeout and on grant change
  always_comb cnt_d = (resp || to || gnt_d != gnt_q) ? '0 : stb_m ? cnt_q + CW'(1) : cnt_q;
  // watchdog counter register
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign to = 1'b0;
`endif
  assign bus.gnt = gnt_q;
  assign bus.wbs_cyc4 = cyc_m;
  assign bus.wbs_stb4 = stb_m & ~to;
  assign bus.wbs_we4 = we_m;
  assign bus.wbs_cab4 = cab_m;
  assign bus.wbs_sel4 = sel_m;
  assign bus.wbs_adr4 = adr_m;
  assign bus.wbs_dat_i4 = dat_m;
  assign bus.wbs_dat64_i4 = d64_m;
  assign bus.m_dat_o = bus.wbs_dat_o4;
  assign bus.m_dat64_o = bus.wbs_dat64_o4;
  assign bus.m_ack_o = gnt_q & {NCH{bus.wbs_ack4}};
  assign bus.m_err_o = gnt_q & {NCH{bus.wbs_err4 | to}};
  assign bus.m_rty_o = gnt_q & {NCH{bus.wbs_rty4}};
endmodule

// File: tb/tb_ss_wb_arb.sv
// tb_ss_wb_arb: vector table, hand sequences and randomized model check of ss_wb_arb
module tb_ss_wb_arb;
  import ssdma_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ss_wb_arb_if #(.AW(AW), .DW(DW)) bus ();
  ss_wb_arb #(
    .AW(AW), .DW(DW)
`ifdef SS_ARB_TIMEOUT_EN
    , .TIMEOUT(15)
`endif
  ) dut (.wb_clk_i(clk), .wb_rst_i(rst), .bus(bus));

  int total = 0;
  int bad = 0;
  logic [3:0] cyc, stb, we, cab;
  logic ack, err, rty;
  logic [AW-1:0] adr_a[NCH];
  logic [DW-1:0] dat_a[NCH], d64_a[NCH];
  logic [3:0] sel_a[NCH];
  logic [DW-1:0] rdat, rdat64;

  typedef struct {
    logic [3:0] cyc;
    logic ack, err, rty;
    logic [3:0] gnt, mack, merr, mrty;
    logic wcyc;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pack();
    for (int n = 0; n < NCH; n++) begin
      bus.m_adr_i[AW*n +: AW] = adr_a[n];
      bus.m_dat_i[DW*n +: DW] = dat_a[n];
      bus.m_dat64_i[DW*n +: DW] = d64_a[n];
      bus.m_sel_i[4*n +: 4] = sel_a[n];
    end
    bus.m_cyc_i = cyc;
    bus.m_stb_i = stb;
    bus.m_we_i = we;
    bus.m_cab_i = cab;
    bus.wbs_ack4 = ack;
    bus.wbs_err4 = err;
    bus.wbs_rty4 = rty;
    bus.wbs_dat_o4 = rdat;
    bus.wbs_dat64_o4 = rdat64;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc = '0; stb = '0; we = '0; cab = '0;
    ack = 1'b0; err = 1'b0; rty = 1'b0;
    rdat = '0; rdat64 = '0;
    for (int n = 0; n < NCH; n++) begin
      adr_a[n] = 32'h1000_0000 * (n + 1) + 32'h40;
      dat_a[n] = 32'hD000_0000 + n;
      d64_a[n] = 32'hE000_0000 + n;
      sel_a[n] = 4'(n + 1);
    end
    pack();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_gnt(input logic [3:0] w);
    int c = 0;
    while (bus.gnt !== w && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("gnt_wait", bus.gnt, w);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int owner, hold, ptr, found, i;
    int order[$];
    int gap;
    logic acked;
    logic [3:0] g, eg;
    tbl[0]  = '{4'b0001, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0001, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1};
    tbl[2]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[3]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[5]  = '{4'b1011, 1'b0, 1'b0, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1'b1};
    tbl[6]  = '{4'b1001, 1'b0, 1'b0, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[7]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b1011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0011, 1'b0, 1'b1, 1'b0, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 1'b0};
    tbl[10] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[11] = '{4'b0011, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[12] = '{4'b0011, 1'b1, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1};

    do_reset();
    #1;
    chk("reset_gnt", bus.gnt, 4'b0000);
    chk("reset_cyc", bus.wbs_cyc4, 1'b0);
    chk("reset_adr", bus.wbs_adr4, '0);
    @(negedge clk);

    for (int v = 0; v < 13; v++) begin
      cyc = tbl[v].cyc; stb = tbl[v].cyc;
      ack = tbl[v].ack; err = tbl[v].err; rty = tbl[v].rty;
      pack();
      #1;
      chk($sformatf("vec%0d_gnt", v), bus.gnt, tbl[v].gnt);
      chk($sformatf("vec%0d_wcyc", v), bus.wbs_cyc4, tbl[v].wcyc);
      chk($sformatf("vec%0d_ack", v), bus.m_ack_o, tbl[v].mack);
      chk($sformatf("vec%0d_err", v), bus.m_err_o, tbl[v].merr);
      chk($sformatf("vec%0d_rty", v), bus.m_rty_o, tbl[v].mrty);
      chk($sformatf("vec%0d_adr", v), bus.wbs_adr4,
          tbl[v].gnt == 4'b0000 ? '0 : {32'h0, adr_a[oh2idx(tbl[v].gnt)]});
      @(negedge clk);
    end

    // all four request continuously, each releases after one ack
    do_reset();
    @(negedge clk);
    order = {};
    gap = 0;
    acked = 1'b0;
    cyc = 4'hF;
    for (int c = 0; c < 100 && order.size() < 5; c++) begin
      g = bus.gnt;
      if (g != 4'b0000) begin
        i = oh2idx(g);
        if (!acked) begin
          ack = 1'b1;
          acked = 1'b1;
          order.push_back(i);
          if (order.size() > 1) chk("rr_gap", 64'(gap >= 1), 64'd1);
          gap = 0;
        end else begin
          ack = 1'b0;
          cyc[i] = 1'b0;
        end
      end else begin
        ack = 1'b0;
        acked = 1'b0;
        cyc = 4'hF;
      end
      stb = cyc;
      pack();
      #1;
      if (!bus.wbs_cyc4) gap++;
      @(negedge clk);
    end
    chk("rr_count", order.size(), 5);
    for (int k = 0; k < 5; k++) if (k < order.size()) chk($sformatf("rr_order%0d", k), order[k], k % 4);
    cyc = '0; stb = '0; ack = 1'b0;
    pack();

    // channel 1 cab burst of 8 beats with a retry on beat 3
    do_reset();
    cyc = 4'b0010; stb = 4'b0010; cab = 4'b0010;
    pack();
    wait_gnt(4'b0010);
    for (int b = 0; b < 8; b++) begin
      ack = (b != 3);
      rty = (b == 3);
      pack();
      #1;
      chk($sformatf("burst%0d_gnt", b), bus.gnt, 4'b0010);
      chk($sformatf("burst%0d_cab", b), bus.wbs_cab4, 1'b1);
      chk($sformatf("burst%0d_rty", b), bus.m_rty_o, b == 3 ? 4'b0010 : 4'b0000);
      chk($sformatf("burst%0d_ack", b), bus.m_ack_o, b == 3 ? 4'b0000 : 4'b0010);
      @(negedge clk);
    end

    // asynchronous reset while busy
    do_reset();
    cyc = 4'b0100; stb = 4'b0100;
    pack();
    wait_gnt(4'b0100);
    #1;
    chk("arst_pre_cyc", bus.wbs_cyc4, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("arst_gnt", bus.gnt, 4'b0000);
    chk("arst_cyc", bus.wbs_cyc4, 1'b0);
    @(negedge clk);

`ifdef SS_ARB_TIMEOUT_EN
    // stalled strobe with no response on channel 0
    do_reset();
    cyc = 4'b0001; stb = 4'b0001;
    pack();
    wait_gnt(4'b0001);
    for (int s = 1; s <= 16; s++) begin
      #1;
      chk($sformatf("to%0d_err", s), bus.m_err_o, s == 15 ? 4'b0001 : 4'b0000);
      chk($sformatf("to%0d_stb", s), bus.wbs_stb4, s == 15 ? 1'b0 : 1'b1);
      chk($sformatf("to%0d_gnt", s), bus.gnt, 4'b0001);
      @(negedge clk);
    end
`endif

    // randomized traffic against a transaction-level ownership model
    do_reset();
    owner = -1; hold = 0; ptr = 0;
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < NCH; n++) begin
        if ($urandom_range(3) == 0) cyc[n] = ~cyc[n];
        stb[n] = cyc[n] & 1'($urandom);
        we[n] = 1'($urandom);
        cab[n] = 1'($urandom);
        adr_a[n] = $urandom;
        dat_a[n] = $urandom;
        d64_a[n] = $urandom;
        sel_a[n] = 4'($urandom);
      end
      ack = ($urandom_range(2) == 0) || (c % 8 == 0);
      err = ($urandom_range(3) == 0);
      rty = ($urandom_range(3) == 0);
      rdat = $urandom;
      rdat64 = $urandom;
      pack();
      #1;
      eg = owner >= 0 ? 4'(1) << owner : 4'b0000;
      chk("rnd_gnt", bus.gnt, eg);
      chk("rnd_cyc", bus.wbs_cyc4, owner >= 0 ? cyc[owner] : 1'b0);
      chk("rnd_stb", bus.wbs_stb4, owner >= 0 ? stb[owner] : 1'b0);
      chk("rnd_we", bus.wbs_we4, owner >= 0 ? we[owner] : 1'b0);
      chk("rnd_sel", bus.wbs_sel4, owner >= 0 ? sel_a[owner] : 4'b0000);
      chk("rnd_adr", bus.wbs_adr4, owner >= 0 ? adr_a[owner] : '0);
      chk("rnd_dat", bus.wbs_dat_i4, owner >= 0 ? dat_a[owner] : '0);
      chk("rnd_dat64", bus.wbs_dat64_i4, owner >= 0 ? d64_a[owner] : '0);
      chk("rnd_ack", bus.m_ack_o, eg & {4{ack}});
      chk("rnd_err", bus.m_err_o, eg & {4{err}});
      chk("rnd_rty", bus.m_rty_o, eg & {4{rty}});
      chk("rnd_rdat", {bus.m_dat64_o, bus.m_dat_o}, {rdat64, rdat});
      if (owner >= 0) begin
        if (!cyc[owner]) begin
          ptr = (owner + 1) % 4;
          owner = -1;
          hold = 1;
        end
      end else if (hold > 0) begin
        hold--;
      end else begin
        found = 0;
        for (int k = 0; k < 4; k++) if (!found && cyc[(ptr + k) % 4]) begin
          owner = (ptr + k) % 4;
          found = 1;
        end
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
